// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage core: register enables/clears,
// ID-stage forward codes, sticky halt and saturating stall/flush counters.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  input  logic             halt_in,
  output logic             pc_en,
  output logic             id_en,
  output logic             id_clr,
  output logic             ex_en,
  output logic             ex_clr,
  output logic             mem_en,
  output logic             mem_clr,
  output logic             wb_en,
  output logic             wb_clr,
  output logic [1:0]       r1_forward,
  output logic [1:0]       r2_forward,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic [1:0] r1_code;
  logic [1:0] r2_code;

  // Newest producer wins: EX (non-load) before MEM; WB is covered by the
  // negedge register-file write.
  function automatic logic [1:0] fwd_code(
    input logic       used,
    input logic [4:0] src,
    input logic [4:0] e_rd,
    input logic       e_wr,
    input logic       e_ld,
    input logic [4:0] m_rd,
    input logic       m_wr
  );
    logic [1:0] code;
    code = 2'd0;
    if (used && src != 5'd0) begin
      if (e_wr && !e_ld && e_rd == src)
        code = 2'd1;
      else if (m_wr && m_rd == src)
        code = 2'd2;
    end
    return code;
  endfunction

  assign load_use = ex_mem_read && ex_reg_write && ex_rd != 5'd0 &&
                    ((id_uses_rs1 && id_rs1 == ex_rd) ||
                     (id_uses_rs2 && id_rs2 == ex_rd));

  assign r1_code = fwd_code(id_uses_rs1, id_rs1, ex_rd, ex_reg_write,
                            ex_mem_read, mem_rd, mem_reg_write);
  assign r2_code = fwd_code(id_uses_rs2, id_rs2, ex_rd, ex_reg_write,
                            ex_mem_read, mem_rd, mem_reg_write);

  always_comb begin
    pc_en     = 1'b1;
    id_en     = 1'b1;
    id_clr    = 1'b0;
    ex_en     = 1'b1;
    ex_clr    = 1'b0;
    mem_en    = 1'b1;
    mem_clr   = 1'b0;
    wb_en     = 1'b1;
    wb_clr    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_nx  = state;
    if (state == HALTED || (state == RUN && halt_in)) begin
      {pc_en, id_en, ex_en, mem_en, wb_en} = 5'b0;
      state_nx = HALTED;
    end else if (state == RUN || state == MEM_WAIT) begin
      state_nx = RUN;
      if (mem_busy) begin
        {pc_en, id_en, ex_en, mem_en} = 4'b0;
        wb_clr    = 1'b1;
        stall_inc = 1'b1;
        state_nx  = MEM_WAIT;
      end else if (state == MEM_WAIT && halt_in) begin
        {pc_en, id_en, ex_en, mem_en, wb_en} = 5'b0;
        state_nx = HALTED;
      end else if (ex_redirect) begin
        id_clr    = 1'b1;
        ex_clr    = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pc_en     = 1'b0;
        id_en     = 1'b0;
        ex_clr    = 1'b1;
        stall_inc = 1'b1;
      end
    end else begin
      state_nx = RUN;
    end
  end

  // Forward codes are forced to 0 whenever the EX register will not capture them.
  assign r1_forward = (id_en && !ex_clr) ? r1_code : 2'd0;
  assign r2_forward = (id_en && !ex_clr) ? r2_code : 2'd0;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      halted       <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nx;
      if (state_nx == HALTED)
        halted <= 1'b1;
      if (stall_inc && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_inc && flush_count != {CNT_W{1'b1}})
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, forwarding, load-use, redirect,
// memory wait, halt and counter saturation (second instance with CNT_W = 2).
module tb_hazard_ctrl;

  // {pc_en, id_en, id_clr, ex_en, ex_clr, mem_en, mem_clr, wb_en, wb_clr}
  localparam logic [8:0] CTL_RUN   = 9'b110101010;
  localparam logic [8:0] CTL_BUSY  = 9'b000000011;
  localparam logic [8:0] CTL_FLUSH = 9'b111111010;
  localparam logic [8:0] CTL_LU    = 9'b000111010;
  localparam logic [8:0] CTL_OFF   = 9'b000000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_reg_write, ex_mem_read;
  logic        mem_reg_write, ex_redirect, mem_busy, halt_in;
  logic        pc_en, id_en, id_clr, ex_en, ex_clr, mem_en, mem_clr, wb_en, wb_clr;
  logic [1:0]  r1_forward, r2_forward, fsm_state;
  logic        halted;
  logic [15:0] stall_cycles, flush_count;
  logic        s_pc_en, s_id_en, s_id_clr, s_ex_en, s_ex_clr, s_mem_en, s_mem_clr;
  logic        s_wb_en, s_wb_clr, s_halted;
  logic [1:0]  s_r1_forward, s_r2_forward, s_fsm_state, s_stall, s_flush;
  logic [8:0]  ctl;
  int          total = 0;
  int          bad = 0;

  assign ctl = {pc_en, id_en, id_clr, ex_en, ex_clr, mem_en, mem_clr, wb_en, wb_clr};

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .halt_in(halt_in), .pc_en(pc_en), .id_en(id_en), .id_clr(id_clr),
    .ex_en(ex_en), .ex_clr(ex_clr), .mem_en(mem_en), .mem_clr(mem_clr),
    .wb_en(wb_en), .wb_clr(wb_clr), .r1_forward(r1_forward), .r2_forward(r2_forward),
    .halted(halted), .stall_cycles(stall_cycles), .flush_count(flush_count),
    .fsm_state(fsm_state)
  );

  hazard_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .halt_in(halt_in), .pc_en(s_pc_en), .id_en(s_id_en), .id_clr(s_id_clr),
    .ex_en(s_ex_en), .ex_clr(s_ex_clr), .mem_en(s_mem_en), .mem_clr(s_mem_clr),
    .wb_en(s_wb_en), .wb_clr(s_wb_clr), .r1_forward(s_r1_forward),
    .r2_forward(s_r2_forward), .halted(s_halted), .stall_cycles(s_stall),
    .flush_count(s_flush), .fsm_state(s_fsm_state)
  );

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0;
    ex_redirect = 1'b0; mem_busy = 1'b0; halt_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (ctl !== CTL_RUN || halted !== 1'b0 || stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
      bad++;
      $display("FAIL reset_idle: ctl=%b halted=%b stall=%0d flush=%0d want ctl=%b 0 0 0",
               ctl, halted, stall_cycles, flush_count, CTL_RUN);
    end
    mem_busy = 1'b1;
    repeat (5) tick();
    total++;
    if (fsm_state !== 2'd1 || stall_cycles !== 16'd5) begin
      bad++;
      $display("FAIL reset_pre_wait: state=%0d stall=%0d want 1 5", fsm_state, stall_cycles);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (fsm_state !== 2'd0 || halted !== 1'b0 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL reset_async: state=%0d halted=%b stall=%0d want 0 0 0",
               fsm_state, halted, stall_cycles);
    end
    idle();
    #1;
    total++;
    if (ctl !== CTL_RUN) begin
      bad++;
      $display("FAIL reset_async_ctl: ctl=%b want %b", ctl, CTL_RUN);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_raw_chain();
    apply_reset();
    ex_rd = 5'd5; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1;
    total++;
    if (r1_forward !== 2'd1 || r2_forward !== 2'd0 || ctl !== CTL_RUN) begin
      bad++;
      $display("FAIL raw_ex: r1=%0d r2=%0d ctl=%b want 1 0 %b", r1_forward, r2_forward, ctl, CTL_RUN);
    end
    ex_reg_write = 1'b0;
    #1;
    total++;
    if (r1_forward !== 2'd2 || r2_forward !== 2'd0) begin
      bad++;
      $display("FAIL raw_mem: r1=%0d r2=%0d want 2 0", r1_forward, r2_forward);
    end
    id_uses_rs1 = 1'b0; id_rs2 = 5'd5;
    #1;
    total++;
    if (r1_forward !== 2'd0 || r2_forward !== 2'd2) begin
      bad++;
      $display("FAIL raw_unused: r1=%0d r2=%0d want 0 2", r1_forward, r2_forward);
    end
    tick();
  endtask

  task automatic test_load_use();
    apply_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
    id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_LU || r2_forward !== 2'd0 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL load_use_stall: ctl=%b r2=%0d stall=%0d want %b 0 0",
               ctl, r2_forward, stall_cycles, CTL_LU);
    end
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_rd = 5'd7; mem_reg_write = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_RUN || r2_forward !== 2'd2 || stall_cycles !== 16'd1) begin
      bad++;
      $display("FAIL load_use_after: ctl=%b r2=%0d stall=%0d want %b 2 1",
               ctl, r2_forward, stall_cycles, CTL_RUN);
    end
    tick();
    total++;
    if (stall_cycles !== 16'd1) begin
      bad++;
      $display("FAIL load_use_single: stall=%0d want 1", stall_cycles);
    end
  endtask

  task automatic test_redirect_over_load_use();
    apply_reset();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd9;
    id_rs1 = 5'd9; id_uses_rs1 = 1'b1; ex_redirect = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_FLUSH || r1_forward !== 2'd0) begin
      bad++;
      $display("FAIL redirect_ctl: ctl=%b r1=%0d want %b 0", ctl, r1_forward, CTL_FLUSH);
    end
    tick();
    total++;
    if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin
      bad++;
      $display("FAIL redirect_cnt: flush=%0d stall=%0d want 1 0", flush_count, stall_cycles);
    end
  endtask

  task automatic test_mem_wait_redirect();
    apply_reset();
    mem_busy = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (ctl !== CTL_BUSY) begin
        bad++;
        $display("FAIL mem_wait_ctl[%0d]: ctl=%b want %b", i, ctl, CTL_BUSY);
      end
      tick();
    end
    total++;
    if (stall_cycles !== 16'd3 || fsm_state !== 2'd1 || flush_count !== 16'd0) begin
      bad++;
      $display("FAIL mem_wait_cnt: stall=%0d state=%0d flush=%0d want 3 1 0",
               stall_cycles, fsm_state, flush_count);
    end
    mem_busy = 1'b0;
    #1;
    total++;
    if (ctl !== CTL_FLUSH) begin
      bad++;
      $display("FAIL mem_wait_exit: ctl=%b want %b", ctl, CTL_FLUSH);
    end
    tick();
    total++;
    if (flush_count !== 16'd1 || stall_cycles !== 16'd3 || fsm_state !== 2'd0) begin
      bad++;
      $display("FAIL mem_wait_done: flush=%0d stall=%0d state=%0d want 1 3 0",
               flush_count, stall_cycles, fsm_state);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    halt_in = 1'b1;
    #1;
    total++;
    if (ctl !== CTL_OFF || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_cycle: ctl=%b halted=%b want %b 0", ctl, halted, CTL_OFF);
    end
    tick();
    halt_in = 1'b0; mem_busy = 1'b1; ex_redirect = 1'b1;
    ex_rd = 5'd3; ex_reg_write = 1'b1; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (ctl !== CTL_OFF || halted !== 1'b1 || r1_forward !== 2'd0) begin
        bad++;
        $display("FAIL halt_hold[%0d]: ctl=%b halted=%b r1=%0d want %b 1 0",
                 i, ctl, halted, r1_forward, CTL_OFF);
      end
      if (i == 1) mem_busy = 1'b0;
      tick();
    end
    total++;
    if (stall_cycles !== 16'd0 || flush_count !== 16'd0 || fsm_state !== 2'd2) begin
      bad++;
      $display("FAIL halt_frozen: stall=%0d flush=%0d state=%0d want 0 0 2",
               stall_cycles, flush_count, fsm_state);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    mem_busy = 1'b1;
    repeat (5) tick();
    total++;
    if (s_stall !== 2'd3 || stall_cycles !== 16'd5) begin
      bad++;
      $display("FAIL sat_stall: narrow=%0d wide=%0d want 3 5", s_stall, stall_cycles);
    end
    mem_busy = 1'b0; ex_redirect = 1'b1;
    repeat (5) tick();
    total++;
    if (s_flush !== 2'd3 || flush_count !== 16'd5 || s_stall !== 2'd3) begin
      bad++;
      $display("FAIL sat_flush: narrow=%0d wide=%0d nstall=%0d want 3 5 3",
               s_flush, flush_count, s_stall);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_chain();
    test_load_use();
    test_redirect_over_load_use();
    test_mem_wait_redirect();
    test_halt();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
